// File: rtl/tb_req_responder.sv
// Single-outstanding request/response responder with a DEPTH-word register array
// and a fixed response latency; reads sample the array on entry to RESP.
//
// state  | meaning
// S_IDLE | req_ready high, waiting for req_valid
// S_WAIT | latency down-counter running
// S_RESP | rsp_valid high, holding response until rsp_ready
module tb_req_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       txn_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [7:0] LAT_M1 = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              oor_q, oor_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       txn_cnt_q, txn_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              req_in_range;
  logic [IDX_W-1:0]  req_idx;

  assign req_in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign req_idx      = req_addr[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    write_d     = write_q;
    oor_d       = oor_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    mem_d       = mem_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          oor_d   = !req_in_range;
          idx_d   = req_idx;
          if (req_write && req_in_range) begin
            mem_d[req_idx] = req_wdata;
          end
          if (ZERO_LAT) begin
            // No wait stage: the read samples the array right at accept.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !req_in_range;
            rsp_rdata_d = (!req_write && req_in_range) ? mem_q[req_idx] : '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = oor_q;
          rsp_rdata_d = (!write_q && !oor_q) ? mem_q[idx_q] : '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          txn_cnt_d   = txn_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      oor_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= 16'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      oor_q       <= oor_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
      mem_q       <= mem_d;
    end
  end

  // Combinational so that reset forces it low immediately.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_tb_req_responder.sv
// Self-checking bench for tb_req_responder: vector table plus scoreboard, with
// hand-written sequences for back-pressure, back-to-back accepts and reset abort.
module tb_tb_req_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] txn_cnt;

  logic        req_valid0 = 1'b0, rsp_ready0 = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [15:0] txn_cnt0;

  int errors = 0;
  int checks = 0;
  int exp_txn = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  tb_req_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .txn_cnt(txn_cnt)
  );

  tb_req_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(1'b0),
    .req_addr(8'd4), .req_wdata(32'h0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .txn_cnt(txn_cnt0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int   k;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_in_time", 32'(k < 20), 32'd1);
    sb.push_back('{exp_rd, exp_err});
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'hxx; req_wdata = 32'hxxxx_xxxx;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_latency", 32'(k), 32'(LAT));
    if (rsp_valid) begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rd);
      chk("rsp_err", 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, e.rd);
        chk("hold_err", 32'(rsp_err), 32'(e.err));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_txn++;
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("txn_cnt", 32'(txn_cnt), 32'(exp_txn));
      chk("ready_after_rsp", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last, n, accepts;

    vecs[0]  = '{1'b0, 8'd3,   32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 8'd5,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 8'd16,  32'h0,        32'h0,        1'b1};
    vecs[4]  = '{1'b1, 8'd200, 32'h12345678, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 8'd8,   32'h0,        32'h0,        1'b0};
    vecs[6]  = '{1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b1, 8'd15,  32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 8'd15,  32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[9]  = '{1'b0, 8'd255, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 8'd0,   32'h00000001, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 8'd0,   32'h0,        32'h00000001, 1'b0};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", 32'(rsp_err), 32'd0);
    chk("reset_txn", 32'(txn_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].err, 0);
      if (i == 2) chk("txn_after_wr_rd", 32'(txn_cnt), 32'd3);
    end

    run_txn(1'b0, 8'd15, 32'h0, 32'hA5A5A5A5, 1'b0, 10);

    // Back-to-back accepts with both handshakes tied high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5; rsp_ready = 1'b1;
    req_valid0 = 1'b1; rsp_ready0 = 1'b1;
    last = -1; n = 0; accepts = 0;
    begin
      int last0;
      last0 = -1;
      for (int i = 0; i < 20; i++) begin
        if (req_valid && req_ready) begin
          if (last >= 0) chk("spacing_lat2", 32'(i - last), 32'(LAT + 2));
          last = i;
          accepts++;
        end
        if (req_valid0 && req_ready0) begin
          if (last0 >= 0) chk("spacing_lat0", 32'(i - last0), 32'd2);
          last0 = i;
          n++;
        end
        if (rsp_valid0) chk("lat0_err", 32'(rsp_err0), 32'd0);
        @(negedge clk);
      end
    end
    req_valid = 1'b0; req_valid0 = 1'b0;
    repeat (6) @(negedge clk);
    rsp_ready = 1'b0; rsp_ready0 = 1'b0;
    chk("b2b_accepts_lat2", 32'(accepts), 32'd5);
    chk("b2b_accepts_lat0", 32'(n), 32'd10);
    exp_txn += accepts;
    chk("b2b_txn_lat2", 32'(txn_cnt), 32'(exp_txn));
    chk("b2b_txn_lat0", 32'(txn_cnt0), 32'(n));
    chk("lat0_rdata_idle", rsp_rdata0, 32'h0);

    // Reset while the latency counter is running aborts the read.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd5;
    @(negedge clk);
    req_valid = 1'b0;
    chk("in_wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_rst", 32'(req_ready), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_txn", 32'(txn_cnt), 32'd0);
    rst = 1'b0;
    exp_txn = 0;
    n = 0;
    @(negedge clk);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) n++;
      @(negedge clk);
    end
    chk("abort_no_rsp", 32'(n), 32'd0);
    run_txn(1'b0, 8'd5, 32'h0, 32'h0, 1'b0, 0);
    run_txn(1'b0, 8'd15, 32'h0, 32'h0, 1'b0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
